// File: rtl/mem_stage_pkg.sv
// Shared widths, ld_op encodings and EX->MS bus layout for the MIPS memory stage.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 147;
  localparam int MS_TO_WS_BUS_WD = 109;
  localparam int DISCARD_W       = 2;
  localparam logic [DISCARD_W-1:0] DISCARD_MAX = '1;

  typedef enum logic [2:0] {
    LD_LW   = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LWL  = 3'd5,
    LD_LWR  = 3'd6,
    LD_NONE = 3'd7
  } ld_op_e;

  typedef struct packed {
    logic [31:0] badvaddr;
    logic [4:0]  ex_code;
    logic        eret;
    logic        bd;
    logic        mem_req;
    ld_op_e      ld_op;
    logic [1:0]  addr_lo;
    logic [31:0] rt_value;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_bus_t;

endpackage

// File: rtl/mem_load_align.sv
// Load-data extraction and extension, including little-endian LWL/LWR merge.
// Purely combinational; no backpressure.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] d_i,
  input  logic [31:0] rt_i,
  input  logic [1:0]  addr_lo_i,
  input  ld_op_e      ld_op_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = d_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_v = d_i[15:8];
      2'd2:    byte_v = d_i[23:16];
      2'd3:    byte_v = d_i[31:24];
      default: byte_v = d_i[7:0];
    endcase
    half_v = addr_lo_i[1] ? d_i[31:16] : d_i[15:0];

    result_o = d_i;
    case (ld_op_i)
      LD_LB:  result_o = {{24{byte_v[7]}}, byte_v};
      LD_LBU: result_o = {24'd0, byte_v};
      LD_LH:  result_o = {{16{half_v[15]}}, half_v};
      LD_LHU: result_o = {16'd0, half_v};
      LD_LWL: begin
        case (addr_lo_i)
          2'd0:    result_o = {d_i[7:0],  rt_i[23:0]};
          2'd1:    result_o = {d_i[15:0], rt_i[15:0]};
          2'd2:    result_o = {d_i[23:0], rt_i[7:0]};
          default: result_o = d_i;
        endcase
      end
      LD_LWR: begin
        case (addr_lo_i)
          2'd1:    result_o = {rt_i[31:24], d_i[31:8]};
          2'd2:    result_o = {rt_i[31:16], d_i[31:16]};
          2'd3:    result_o = {rt_i[31:8],  d_i[31:24]};
          default: result_o = d_i;
        endcase
      end
      default: result_o = d_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: one-entry valid/allowin register waiting on data_ok, zero added latency when data
// arrives in the MS cycle; holds (buffering the beat) while WB stalls, drops beats orphaned by flushes.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0]  es_to_ms_bus,
  output logic                        ms_allowin,
  input  logic                        ws_allowin,
  output logic                        ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0]  ms_to_ws_bus,
  input  logic                        data_sram_data_ok,
  input  logic [31:0]                 data_sram_rdata,
  input  logic                        es_req_cancel,
  input  logic                        flush,
  output logic                        MS_EX,
  output logic [4:0]                  MEM_dest,
  output logic [31:0]                 MEM_dest_data,
  output logic                        ms_ld_pending
);

  es_bus_t              es_bus;
  logic                 ms_valid_q, ms_valid_d;
  es_bus_t              bus_q, bus_d;
  logic                 buf_valid_q, buf_valid_d;
  logic [31:0]          rdata_buf_q, rdata_buf_d;
  logic [DISCARD_W-1:0] discard_cnt_q, discard_cnt_d;
  logic [DISCARD_W:0]   discard_sum;

  logic        discard_beat, beat_free, attributed, ms_ready_go, handoff, flush_orphan;
  logic [31:0] load_data, align_result, final_result;

  assign es_bus = es_bus_t'(es_to_ms_bus);

  // Beats are owed to flushed requests first; only a free beat can belong to the MS instruction.
  assign discard_beat = data_sram_data_ok & (discard_cnt_q != '0);
  assign beat_free    = data_sram_data_ok & (discard_cnt_q == '0);
  assign attributed   = beat_free & ms_valid_q & bus_q.mem_req & !buf_valid_q;
  assign ms_ready_go  = !bus_q.mem_req | buf_valid_q | beat_free;

  assign ms_allowin     = !ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go & !flush;
  assign handoff        = ms_to_ws_valid & ws_allowin;
  assign flush_orphan   = flush & ms_valid_q & bus_q.mem_req & !buf_valid_q & !attributed;

  always_comb begin
    discard_sum = {1'b0, discard_cnt_q}
                + {{DISCARD_W{1'b0}}, flush_orphan}
                + {{DISCARD_W{1'b0}}, es_req_cancel}
                - {{DISCARD_W{1'b0}}, discard_beat};
    discard_cnt_d = (discard_sum > {1'b0, DISCARD_MAX}) ? DISCARD_MAX : discard_sum[DISCARD_W-1:0];
  end

  always_comb begin
    ms_valid_d  = ms_valid_q;
    bus_d       = bus_q;
    buf_valid_d = buf_valid_q;
    rdata_buf_d = rdata_buf_q;
    if (flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
      if (es_to_ms_valid) bus_d = es_bus;
    end
    // An attributed beat that is not handed off this cycle can only mean WB is stalling.
    if (flush || handoff) begin
      buf_valid_d = 1'b0;
    end else if (attributed) begin
      buf_valid_d = 1'b1;
      rdata_buf_d = data_sram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_q    <= 1'b0;
      bus_q         <= '0;
      buf_valid_q   <= 1'b0;
      rdata_buf_q   <= 32'd0;
      discard_cnt_q <= '0;
    end else begin
      ms_valid_q    <= ms_valid_d;
      bus_q         <= bus_d;
      buf_valid_q   <= buf_valid_d;
      rdata_buf_q   <= rdata_buf_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  assign load_data = buf_valid_q ? rdata_buf_q : data_sram_rdata;

  mem_load_align u_align (
    .d_i       (load_data),
    .rt_i      (bus_q.rt_value),
    .addr_lo_i (bus_q.addr_lo),
    .ld_op_i   (bus_q.ld_op),
    .result_o  (align_result)
  );

  assign final_result = (bus_q.ld_op == LD_NONE) ? bus_q.alu_result : align_result;

  assign ms_to_ws_bus  = {bus_q.badvaddr, bus_q.ex_code, bus_q.eret, bus_q.bd, bus_q.gr_we,
                          bus_q.dest, final_result, bus_q.pc};
  assign MS_EX         = ms_valid_q & ((bus_q.ex_code != 5'd0) | bus_q.eret);
  assign MEM_dest      = bus_q.dest & {5{ms_valid_q}};
  assign MEM_dest_data = final_result;
  assign ms_ld_pending = ms_valid_q & bus_q.mem_req & bus_q.gr_we & !ms_ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: plays EX, WB and the data SRAM; random traffic against a transaction model,
// then directed buffering, flush/cancel and mid-wait reset scenarios.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         es_to_ms_valid;
  logic [146:0] es_to_ms_bus;
  logic         ms_allowin;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [108:0] ms_to_ws_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         es_req_cancel;
  logic         flush;
  logic         MS_EX;
  logic [4:0]   MEM_dest;
  logic [31:0]  MEM_dest_data;
  logic         ms_ld_pending;

  mem_stage dut (
    .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_allowin(ms_allowin), .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_to_ws_bus(ms_to_ws_bus), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .es_req_cancel(es_req_cancel), .flush(flush),
    .MS_EX(MS_EX), .MEM_dest(MEM_dest), .MEM_dest_data(MEM_dest_data),
    .ms_ld_pending(ms_ld_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [146:0] mk_bus(input logic [31:0] badv, input logic [4:0] exc,
      input logic eret, input logic bd, input logic mem, input logic [2:0] op, input logic [1:0] a,
      input logic [31:0] rt, input logic we, input logic [4:0] dest, input logic [31:0] alu,
      input logic [31:0] pc);
    return {badv, exc, eret, bd, mem, op, a, rt, we, dest, alu, pc};
  endfunction

  function automatic logic [146:0] lw_bus(input logic [31:0] pc, input logic [4:0] dest);
    return mk_bus(32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 32'd0, 1'b1, dest, 32'd0, pc);
  endfunction

  // Reference load result from the architectural rules, written with shifts and masks.
  function automatic logic [31:0] ref_load(input int op, input int a, input logic [31:0] d,
      input logic [31:0] rt, input logic [31:0] alu);
    logic [31:0] b, h;
    b = (d >> (8 * a)) & 32'hff;
    h = (d >> (16 * (a / 2))) & 32'hffff;
    case (op)
      0:       return d;
      1:       return (b ^ 32'h80) - 32'h80;
      2:       return b;
      3:       return (h ^ 32'h8000) - 32'h8000;
      4:       return h;
      5:       return (d << (8 * (3 - a))) | (rt & (32'hffffffff >> (8 * (a + 1))));
      6:       return (d >> (8 * a)) | (rt & ~(32'hffffffff >> (8 * a)));
      default: return alu;
    endcase
  endfunction

  typedef struct {
    logic [146:0] bus;
    logic [108:0] exp_out;
    logic [31:0]  rdata;
    logic [4:0]   dest;
    logic         mem_req;
    logic         gr_we;
    logic         ex;
    logic         fixed;
  } txn_t;

  logic [2:0]  dir_op  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
  logic [1:0]  dir_a   [6] = '{2'd0, 2'd3, 2'd3, 2'd2, 2'd1, 2'd2};
  logic [31:0] dir_d   [6] = '{32'h12345678, 32'h80FFFFFF, 32'h80FFFFFF, 32'h80015A5A,
                               32'h11223344, 32'h11223344};
  logic [31:0] dir_exp [6] = '{32'h12345678, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8001,
                               32'h3344CCDD, 32'hAABB1122};

  txn_t        cur, ex_txn;
  logic        in_ms, got_data, ex_has, resp_pending, ready, exp_v, exp_allow;
  int          resp_wait, gen_idx, kind;
  logic [31:0] t_badv, t_rt, t_alu, t_pc, t_d, t_res;
  logic [4:0]  t_exc, t_dest;
  logic [2:0]  t_op;
  logic [1:0]  t_a;
  logic        t_eret, t_bd, t_mem, t_we;

  task automatic next_cycle();
    @(posedge clk);
    #1;
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b0;
    flush             = 1'b0;
    es_req_cancel     = 1'b0;
    ws_allowin        = 1'b1;
    data_sram_rdata   = $urandom;
  endtask

  task automatic build_txn();
    t_badv = $urandom; t_rt = $urandom; t_alu = $urandom; t_d = $urandom;
    t_pc = 32'hBFC00100 + 32'(gen_idx * 4);
    t_dest = 5'($urandom_range(1, 31)); t_bd = 1'($urandom);
    if (gen_idx < 6) begin
      t_op = dir_op[gen_idx]; t_a = dir_a[gen_idx]; t_d = dir_d[gen_idx];
      t_rt = (gen_idx >= 4) ? 32'hAABBCCDD : t_rt;
      t_mem = 1'b1; t_we = 1'b1; t_exc = 5'd0; t_eret = 1'b0; t_badv = 32'd0;
      t_res = dir_exp[gen_idx];
    end else begin
      kind   = int'($urandom_range(0, 9));
      t_op   = (kind >= 4) ? 3'($urandom_range(0, 6)) : 3'd7;
      t_a    = 2'($urandom);
      t_mem  = (kind >= 3);
      t_exc  = (kind == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      t_eret = (kind == 1);
      t_we   = (kind >= 4) || (kind == 2);
      t_res  = ref_load(int'(t_op), int'(t_a), t_d, t_rt, t_alu);
    end
    ex_txn.bus     = mk_bus(t_badv, t_exc, t_eret, t_bd, t_mem, t_op, t_a, t_rt, t_we, t_dest, t_alu, t_pc);
    ex_txn.exp_out = {t_badv, t_exc, t_eret, t_bd, t_we, t_dest, t_res, t_pc};
    ex_txn.rdata   = t_d;
    ex_txn.dest    = t_dest;
    ex_txn.mem_req = t_mem;
    ex_txn.gr_we   = t_we;
    ex_txn.ex      = (t_exc != 5'd0) || t_eret;
    ex_txn.fixed   = (gen_idx < 6);
  endtask

  initial begin
    reset = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b1;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0; es_req_cancel = 1'b0; flush = 1'b0;
    #3;
    chk("rst_allowin", ms_allowin, 1'b1);
    chk("rst_out_vld", ms_to_ws_valid, 1'b0);
    chk("rst_ws_bus", ms_to_ws_bus, 109'd0);
    chk("rst_ms_ex", MS_EX, 1'b0);
    chk("rst_dest", MEM_dest, 5'd0);
    chk("rst_dest_data", MEM_dest_data, 32'd0);
    chk("rst_ld_pend", ms_ld_pending, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    in_ms = 0; got_data = 0; ex_has = 0; resp_pending = 0; resp_wait = 0; gen_idx = 0;
    cur = '{default: '0}; ex_txn = '{default: '0};
    for (int cyc = 0; cyc < 3050; cyc++) begin
      @(posedge clk);
      #1;
      ws_allowin        = (gen_idx <= 6) ? 1'b1 : ($urandom_range(0, 9) < 7);
      data_sram_data_ok = resp_pending && (resp_wait == 0);
      data_sram_rdata   = data_sram_data_ok ? cur.rdata : $urandom;
      flush = 1'b0; es_req_cancel = 1'b0;
      if (!ex_has && cyc < 3000 && (gen_idx < 6 || $urandom_range(0, 9) < 6)) begin
        build_txn();
        ex_has = 1'b1;
        gen_idx++;
      end
      es_to_ms_valid = ex_has;
      es_to_ms_bus   = ex_txn.bus;

      @(negedge clk);
      ready     = !cur.mem_req || got_data || data_sram_data_ok;
      exp_v     = in_ms && ready;
      exp_allow = !in_ms || (ready && ws_allowin);
      chk("allowin", ms_allowin, exp_allow);
      chk("out_vld", ms_to_ws_valid, exp_v);
      chk("ld_pend", ms_ld_pending, in_ms && cur.mem_req && cur.gr_we && !ready);
      chk("mem_dest", MEM_dest, in_ms ? cur.dest : 5'd0);
      chk("ms_ex", MS_EX, in_ms && cur.ex);
      if (exp_v) chk("ws_bus", ms_to_ws_bus, cur.exp_out);
      if (in_ms && data_sram_data_ok) got_data = 1'b1;
      if (exp_v && ws_allowin) in_ms = 1'b0;
      if (resp_pending) begin
        if (data_sram_data_ok) resp_pending = 1'b0;
        else resp_wait--;
      end
      if (ex_has && exp_allow) begin
        in_ms = 1'b1; cur = ex_txn; got_data = 1'b0; ex_has = 1'b0;
        if (cur.mem_req) begin
          resp_pending = 1'b1;
          resp_wait = cur.fixed ? 0 : int'($urandom_range(0, 3));
        end
      end
    end
    chk("drain_done", {in_ms, ex_has}, 2'b00);

    // WB stalls three cycles after the beat: data must come from the buffer.
    next_cycle(); es_to_ms_valid = 1'b1; es_to_ms_bus = lw_bus(32'h100, 5'd3); ws_allowin = 1'b0;
    @(negedge clk); chk("buf_allow_empty", ms_allowin, 1'b1);
    next_cycle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFEBABE; ws_allowin = 1'b0;
    @(negedge clk); chk("buf_vld", ms_to_ws_valid, 1'b1); chk("buf_allow", ms_allowin, 1'b0);
    for (int i = 0; i < 2; i++) begin
      next_cycle(); ws_allowin = 1'b0;
      @(negedge clk);
      chk("buf_hold_allow", ms_allowin, 1'b0);
      chk("buf_hold_data", MEM_dest_data, 32'hCAFEBABE);
      chk("buf_hold_pend", ms_ld_pending, 1'b0);
    end
    next_cycle(); es_to_ms_valid = 1'b1; es_to_ms_bus = lw_bus(32'h104, 5'd4);
    @(negedge clk); chk("buf_release", ms_to_ws_bus[63:32], 32'hCAFEBABE); chk("buf_rel_allow", ms_allowin, 1'b1);
    next_cycle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BADF00D;
    @(negedge clk); chk("buf_next_vld", ms_to_ws_valid, 1'b1); chk("buf_next_data", MEM_dest_data, 32'h0BADF00D);

    // Flush plus cancel leaves two orphaned beats ahead of the next load.
    next_cycle(); es_to_ms_valid = 1'b1; es_to_ms_bus = lw_bus(32'h180, 5'd5);
    next_cycle(); flush = 1'b1; es_req_cancel = 1'b1;
    @(negedge clk); chk("fl_out_vld", ms_to_ws_valid, 1'b0); chk("fl_pend", ms_ld_pending, 1'b1);
    next_cycle(); es_to_ms_valid = 1'b1; es_to_ms_bus = lw_bus(32'h184, 5'd6);
    @(negedge clk); chk("fl_allow", ms_allowin, 1'b1); chk("fl_empty_vld", ms_to_ws_valid, 1'b0);
    for (int i = 0; i < 2; i++) begin
      next_cycle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD0000 + 32'(i);
      @(negedge clk); chk("fl_drop_vld", ms_to_ws_valid, 1'b0); chk("fl_drop_pend", ms_ld_pending, 1'b1);
    end
    next_cycle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h600DBEEF;
    @(negedge clk); chk("fl_third_vld", ms_to_ws_valid, 1'b1); chk("fl_third_data", MEM_dest_data, 32'h600DBEEF);
    next_cycle();
    @(negedge clk); chk("fl_idle_vld", ms_to_ws_valid, 1'b0);

    // Reset while a load waits behind an orphaned beat.
    next_cycle(); es_to_ms_valid = 1'b1; es_to_ms_bus = lw_bus(32'h200, 5'd7);
    next_cycle(); flush = 1'b1;
    next_cycle(); es_to_ms_valid = 1'b1; es_to_ms_bus = lw_bus(32'h204, 5'd8);
    next_cycle();
    @(negedge clk); chk("rst_pre_pend", ms_ld_pending, 1'b1);
    #1 data_sram_rdata = 32'd0; reset = 1'b1;
    #1;
    chk("mrst_allowin", ms_allowin, 1'b1);
    chk("mrst_out_vld", ms_to_ws_valid, 1'b0);
    chk("mrst_ws_bus", ms_to_ws_bus, 109'd0);
    chk("mrst_dest", MEM_dest, 5'd0);
    chk("mrst_pend", ms_ld_pending, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    next_cycle();
    @(negedge clk); chk("post_rst_vld", ms_to_ws_valid, 1'b0); chk("post_rst_allow", ms_allowin, 1'b1);
    next_cycle(); es_to_ms_valid = 1'b1; es_to_ms_bus = lw_bus(32'h208, 5'd9);
    next_cycle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5EED1234;
    @(negedge clk); chk("post_rst_ld_vld", ms_to_ws_valid, 1'b1); chk("post_rst_ld_data", MEM_dest_data, 32'h5EED1234);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
